// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: FSM state
// encoding, the ISA word width, the default watchdog limit and the
// access-detect helper used by the controller.
package mem_access_ctrl_pkg;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_TIMEOUT = 64;
  // Watchdog counter width; covers the full 2..255 timeout range.
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mac_state_e;

  // A live instruction in ex_mem that touches data memory.
  function automatic logic mac_is_access(input logic valid,
                                         input logic rd,
                                         input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// mem_timeout_ctr: saturating up-counter with synchronous clear and count
// enable. tc_o flags the last cycle before the count would reach MAX, so
// an owner that acts on tc_o fires after exactly MAX enabled cycles.
module mem_timeout_ctr
  import mem_access_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int MAX   = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable; the count sticks at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(MAX - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller between ex_mem and the
// data memory. Issues one load/store per instruction, holds the request
// while the memory stalls, waits for completion and returns load data to
// mem_wb. stall_n freezes the pipeline while an access is outstanding.
//
// Optional build macro ALIGN_CHECK_EN: when defined, an access with
// in_addr[0] = 1 is rejected (err set, no memory request, pipeline not
// stalled). When undefined, addresses are passed through unchecked.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access outstanding; a new request is presented directly
//         | from ex_mem and may complete in the same cycle (hit)
// ST_REQ  | memory stalled the request; re-present it every cycle
// ST_WAIT | request accepted; waiting for mem_done under the watchdog
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int ADDR_W         = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_data_out,
  input  logic              mem_stall,
  input  logic              mem_done,
  output logic [ADDR_W-1:0] out_mem_out,
  output logic              stall_n,
  output logic              busy,
  output logic              err
);

  mac_state_e        state_q;
  mac_state_e        state_d;
  logic [ADDR_W-1:0] hold_q;
  logic              err_q;
  logic              op_store_q;

  logic acc;
  logic misaligned;
  logic completing;
  logic err_set;
  logic cnt_en;
  logic cnt_clr;
  logic tc;
  logic cur_store;
  logic hold_we;

  assign acc = mac_is_access(in_valid, in_mem_rd, in_mem_wr);

  // Misaligned-access detect; constant 0 when alignment is the memory's job.
`ifdef ALIGN_CHECK_EN
  assign misaligned = acc & in_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Rd+wr together is treated as a store. Once in WAIT the op type comes
  // from the register captured at issue rather than from ex_mem.
  assign cur_store = (state_q == ST_WAIT) ? op_store_q : in_mem_wr;

  // Next state, request lines, stall and watchdog control. While rst is
  // high every output is held at its reset value even if ex_mem is live.
  always_comb begin
    state_d     = state_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    stall_n     = 1'b1;
    busy        = 1'b0;
    completing  = 1'b0;
    err_set     = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b1;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            err_set = (in_mem_rd & in_mem_wr) | misaligned;
            if (!misaligned) begin
              mem_rd      = ~in_mem_wr;
              mem_wr      = in_mem_wr;
              mem_addr    = in_addr;
              mem_data_in = in_wr_data;
              if (mem_stall) begin
                state_d = ST_REQ;
                stall_n = 1'b0;
              end else if (mem_done) begin
                completing = 1'b1;
              end else begin
                state_d = ST_WAIT;
                stall_n = 1'b0;
              end
              busy = ~completing;
            end
          end
        end
        ST_REQ: begin
          // ex_mem is frozen, so the inputs still describe the same request.
          mem_rd      = ~in_mem_wr;
          mem_wr      = in_mem_wr;
          mem_addr    = in_addr;
          mem_data_in = in_wr_data;
          stall_n     = 1'b0;
          busy        = 1'b1;
          if (!mem_stall) begin
            if (mem_done) begin
              completing = 1'b1;
              stall_n    = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          stall_n = 1'b0;
          busy    = 1'b1;
          cnt_en  = 1'b1;
          cnt_clr = 1'b0;
          if (mem_done) begin
            completing = 1'b1;
            stall_n    = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = ST_IDLE;
          end else if (tc) begin
            // Watchdog: give up on the memory and release the pipeline.
            err_set = 1'b1;
            stall_n = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  mem_timeout_ctr #(
    .CNT_W (CNT_W),
    .MAX   (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  // FSM state, sticky error and the op type latched for the WAIT phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      op_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
      if (state_q != ST_WAIT) begin
        op_store_q <= in_mem_wr;
      end
    end
  end

  assign hold_we = completing & ~cur_store;

  // Load-data hold register: written only when a load completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (hold_we) begin
      hold_q <= mem_data_out;
    end
  end

  assign out_mem_out = completing ? mem_data_out : hold_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_rd, in_mem_wr;
  logic [15:0] in_addr, in_wr_data;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, out_mem_out;
  logic        mem_rd, mem_wr, mem_stall, mem_done;
  logic        stall_n, busy, err;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] hold_m  = 16'h0000;
  logic        err_m   = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_mem_rd    (in_mem_rd),
    .in_mem_wr    (in_mem_wr),
    .in_addr      (in_addr),
    .in_wr_data   (in_wr_data),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .out_mem_out  (out_mem_out),
    .stall_n      (stall_n),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d);
    in_valid = v; in_mem_rd = rd; in_mem_wr = wr; in_addr = a; in_wr_data = d;
  endtask

  task automatic set_mem(input logic st, input logic dn, input logic [15:0] d);
    mem_stall = st; mem_done = dn; mem_data_out = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    n_total++; if ({mem_rd, mem_wr, stall_n, busy, err} !== 5'b00100) $display("FAIL reset_ctl: got %b want 00100", {mem_rd, mem_wr, stall_n, busy, err}); else n_pass++;
    n_total++; if (out_mem_out !== 16'h0) $display("FAIL reset_out: got %h want 0000", out_mem_out); else n_pass++;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_hit();
    set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    set_mem(1'b0, 1'b1, 16'hBEEF);
    @(negedge clk);
    n_total++; if ({mem_rd, mem_wr, stall_n} !== 3'b101) $display("FAIL hit_ctl: got %b want 101", {mem_rd, mem_wr, stall_n}); else n_pass++;
    n_total++; if (mem_addr !== 16'h0010) $display("FAIL hit_addr: got %h want 0010", mem_addr); else n_pass++;
    n_total++; if (out_mem_out !== 16'hBEEF) $display("FAIL hit_out: got %h want beef", out_mem_out); else n_pass++;
    cyc();
    hold_m = 16'hBEEF;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 16'h1111);
    @(negedge clk);
    n_total++; if ({mem_rd, stall_n} !== 2'b01) $display("FAIL hit_pulse: got %b want 01", {mem_rd, stall_n}); else n_pass++;
    n_total++; if (out_mem_out !== hold_m) $display("FAIL hit_hold: got %h want %h", out_mem_out, hold_m); else n_pass++;
    cyc();
  endtask

  task automatic test_miss();
    int lows = 0;
    int wr_hi = 0;
    set_in(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234);
    for (int c = 0; c < 4; c++) begin
      set_mem(1'b0, c == 3, 16'hAAAA);
      @(negedge clk);
      if (!stall_n) lows++;
      if (mem_wr) wr_hi++;
      if (c == 0) begin
        n_total++; if (mem_data_in !== 16'h1234) $display("FAIL miss_wdata: got %h want 1234", mem_data_in); else n_pass++;
      end
      cyc();
    end
    n_total++; if (lows !== 3) $display("FAIL miss_stall_cycles: got %0d want 3", lows); else n_pass++;
    n_total++; if (wr_hi !== 1) $display("FAIL miss_wr_cycles: got %0d want 1", wr_hi); else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    n_total++; if (out_mem_out !== hold_m) $display("FAIL miss_hold: got %h want %h", out_mem_out, hold_m); else n_pass++;
    cyc();
  endtask

  task automatic test_busy_mem();
    int rd_hi = 0;
    int lows = 0;
    int addr_bad = 0;
    set_in(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
    for (int c = 0; c < 4; c++) begin
      set_mem(c < 2, c == 3, (c == 3) ? 16'h5A5A : 16'hDEAD);
      @(negedge clk);
      if (mem_rd) begin
        rd_hi++;
        if (mem_addr !== 16'h0030) addr_bad++;
      end
      if (!stall_n) lows++;
      if (c == 3) begin
        n_total++; if (out_mem_out !== 16'h5A5A) $display("FAIL busy_out: got %h want 5a5a", out_mem_out); else n_pass++;
      end
      cyc();
    end
    hold_m = 16'h5A5A;
    n_total++; if (rd_hi !== 3) $display("FAIL busy_rd_cycles: got %0d want 3", rd_hi); else n_pass++;
    n_total++; if (lows !== 3) $display("FAIL busy_stall_cycles: got %0d want 3", lows); else n_pass++;
    n_total++; if (addr_bad !== 0) $display("FAIL busy_addr_stable: got %0d bad want 0", addr_bad); else n_pass++;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    n_total++; if (out_mem_out !== hold_m) $display("FAIL busy_hold: got %h want %h", out_mem_out, hold_m); else n_pass++;
    cyc();
  endtask

  task automatic test_timeout();
    set_in(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
    for (int c = 0; c <= TO; c++) begin
      set_mem(1'b0, 1'b0, 16'h7777);
      @(negedge clk);
      n_total++; if ({stall_n, busy, err} !== {c == TO, 1'b1, 1'b0}) $display("FAIL timeout_c%0d: got %b want %b", c, {stall_n, busy, err}, {c == TO, 1'b1, 1'b0}); else n_pass++;
      cyc();
    end
    err_m = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      set_mem(1'b0, 1'b1, 16'h9999);
      @(negedge clk);
      n_total++; if ({stall_n, busy, err, mem_rd} !== 4'b1010) $display("FAIL timeout_after_%0d: got %b want 1010", c, {stall_n, busy, err, mem_rd}); else n_pass++;
      n_total++; if (out_mem_out !== hold_m) $display("FAIL timeout_hold_%0d: got %h want %h", c, out_mem_out, hold_m); else n_pass++;
      cyc();
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0);
    set_mem(1'b0, 1'b0, 16'h0);
    cyc();
    @(negedge clk);
    n_total++; if ({stall_n, busy} !== 2'b01) $display("FAIL areset_pre: got %b want 01", {stall_n, busy}); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if ({mem_rd, mem_wr, stall_n, busy, err} !== 5'b00100) $display("FAIL areset_ctl: got %b want 00100", {mem_rd, mem_wr, stall_n, busy, err}); else n_pass++;
    n_total++; if (out_mem_out !== 16'h0) $display("FAIL areset_out: got %h want 0000", out_mem_out); else n_pass++;
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    hold_m = 16'h0000;
    err_m = 1'b0;
  endtask

  task automatic test_align();
    set_in(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0);
    set_mem(1'b0, 1'b1, 16'h0F0F);
    @(negedge clk);
`ifdef ALIGN_CHECK_EN
    n_total++; if ({mem_rd, stall_n, busy} !== 3'b010) $display("FAIL align_ctl: got %b want 010", {mem_rd, stall_n, busy}); else n_pass++;
    n_total++; if (out_mem_out !== hold_m) $display("FAIL align_out: got %h want %h", out_mem_out, hold_m); else n_pass++;
    cyc();
    err_m = 1'b1;
`else
    n_total++; if ({mem_rd, stall_n} !== 2'b11) $display("FAIL align_ctl: got %b want 11", {mem_rd, stall_n}); else n_pass++;
    n_total++; if (mem_addr !== 16'h0011) $display("FAIL align_addr: got %h want 0011", mem_addr); else n_pass++;
    cyc();
    hold_m = 16'h0F0F;
`endif
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_mem(1'b0, 1'b0, 16'h0);
    @(negedge clk);
    n_total++; if (err !== err_m) $display("FAIL align_err: got %b want %b", err, err_m); else n_pass++;
    cyc();
  endtask

  // Each transaction: s stall cycles, then accept; done d cycles after the
  // accept, or never (d > TO) so the watchdog ends it TO cycles after.
  task automatic test_random();
    for (int t = 0; t < 150; t++) begin
      int          s, d, e, kind;
      logic        rd, wr, conf, cmp;
      logic [15:0] a, wd, rdv;
      logic [4:0]  exp_v;
      kind = $urandom_range(0, 19);
      rd   = (kind < 10) || (kind == 19);
      wr   = (kind >= 10);
      conf = rd & wr;
      a    = 16'($urandom) & 16'hFFFE;
      wd   = 16'($urandom);
      rdv  = 16'($urandom);
      s    = $urandom_range(0, 3);
      d    = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      cmp  = (d <= TO);
      e    = cmp ? s + d : s + TO;
      set_in(1'b1, rd, wr, a, wd);
      for (int c = 0; c <= e; c++) begin
        set_mem(c < s, c == s + d, (c == s + d) ? rdv : 16'($urandom));
        @(negedge clk);
        exp_v = {(c <= s) && !wr, (c <= s) && wr, c == e, e != 0, (c == 0) ? err_m : (err_m | conf)};
        n_total++; if ({mem_rd, mem_wr, stall_n, busy, err} !== exp_v) $display("FAIL rnd_ctl t%0d c%0d: got %b want %b", t, c, {mem_rd, mem_wr, stall_n, busy, err}, exp_v); else n_pass++;
        n_total++; if ({mem_addr, mem_data_in} !== ((c <= s) ? {a, wd} : 32'h0)) $display("FAIL rnd_req t%0d c%0d: got %h want %h", t, c, {mem_addr, mem_data_in}, (c <= s) ? {a, wd} : 32'h0); else n_pass++;
        n_total++; if (out_mem_out !== ((c == e && cmp) ? rdv : hold_m)) $display("FAIL rnd_out t%0d c%0d: got %h want %h", t, c, out_mem_out, (c == e && cmp) ? rdv : hold_m); else n_pass++;
        cyc();
      end
      if (cmp && !wr) hold_m = rdv;
      if (!cmp || conf) err_m = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        set_in($urandom_range(0, 1) == 1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        if (!in_valid) begin
          in_mem_rd = 1'($urandom);
          in_mem_wr = 1'($urandom);
        end
        set_mem(1'($urandom), 1'($urandom), 16'($urandom));
        @(negedge clk);
        n_total++; if ({mem_rd, mem_wr, stall_n, busy, err} !== {4'b0010, err_m}) $display("FAIL rnd_gap_ctl t%0d: got %b want %b", t, {mem_rd, mem_wr, stall_n, busy, err}, {4'b0010, err_m}); else n_pass++;
        n_total++; if (out_mem_out !== hold_m) $display("FAIL rnd_gap_out t%0d: got %h want %h", t, out_mem_out, hold_m); else n_pass++;
        cyc();
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_busy_mem();
    test_timeout();
    test_async_reset();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller. Sits between the ex_mem pipeline register and the data memory/cache. Feeds the mem_wb pipeline register.
- Issues one load or store per instruction to a multi-cycle, stallable data memory and holds the request until the memory accepts it.
- Waits for completion and returns load data.
- Drives stall_n low for mem_wb and all upstream pipeline registers while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the watchdog error fires (range 2..255).
- ADDR_W, 16, address/data width (fixed ISA word width).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  ex_mem holds a live instruction.
- in_mem_rd  in  1  instruction is a load.
- in_mem_wr  in  1  instruction is a store.
- in_addr  in  16  effective address (ALU result).
- in_wr_data  in  16  store data.
- mem_addr  out  16  address to the data memory.
- mem_data_in  out  16  write data to the data memory.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_data_out  in  16  read data from the memory.
- mem_stall  in  1  memory busy; a request presented this cycle is not accepted.
- mem_done  in  1  access complete; mem_data_out valid this cycle.
- out_mem_out  out  16  load data to mem_wb.
- stall_n  out  1  0 = freeze all pipeline registers up to and including mem_wb.
- busy  out  1  an access is outstanding (debug/perf).
- err  out  1  sticky error flag.

Behaviour:
- State machine: IDLE, REQ, WAIT. State encoding goes in the shared package.
- Reset (asynchronous, any state, mid-access included):
  - state = IDLE; all outputs 0 except stall_n = 1.
  - out_mem_out hold register = 0; err = 0; timeout counter = 0.
  - Any in-flight memory transaction is abandoned.
- Access condition: acc = in_valid & (in_mem_rd | in_mem_wr).
- If in_mem_rd and in_mem_wr are both 1, the access is treated as a store and err is set.
- IDLE:
  - If !acc: mem_rd = mem_wr = 0, stall_n = 1, stay in IDLE.
  - If acc, drive mem_rd/mem_wr, mem_addr = in_addr and mem_data_in = in_wr_data combinationally in the same cycle.
  - Request not accepted (mem_stall = 1): go to REQ; stall_n = 0.
  - Accepted (mem_stall = 0) with mem_done = 1 (hit): complete in the same cycle; stall_n = 1; stay in IDLE. Zero added latency.
  - Accepted with mem_done = 0: go to WAIT; stall_n = 0.
- REQ:
  - Re-present the identical request every cycle. ex_mem is frozen, so the inputs are stable.
  - stall_n = 0.
  - On mem_stall = 0, move to WAIT, or complete immediately if mem_done = 1.
- WAIT:
  - Request lines are 0; stall_n = 0; the counter increments each cycle.
  - On mem_done = 1: stall_n = 1 that cycle; load data is captured into the hold register; counter clears; go to IDLE.
- Load data output:
  - out_mem_out = mem_data_out in the completion cycle.
  - Otherwise out_mem_out = hold register, which keeps its value across stalls.
  - Stores leave the hold register unchanged.
- busy = (state != IDLE) | (acc & !completing).
- stall_n is combinational. Its 0 → 1 transition occurs exactly in the completion cycle, so mem_wb latches the result on that edge.
- Watchdog:
  - If the counter reaches TIMEOUT_CYCLES, err is set, the FSM forces itself to IDLE, and stall_n = 1 (the pipeline is released).
  - Load data in that case is the previous hold value.
- err is sticky until reset.
- A mem_done while in IDLE with no request is ignored.
- Back-to-back accesses: after a completion in IDLE, the next instruction's request may issue on the following cycle. No bubble is required.

Optional Feature:
- ALIGN_CHECK_EN
  - Defined: acc with in_addr[0] = 1 (misaligned word access) sets err. No memory request is issued; stall_n stays 1; out_mem_out holds its value.
  - Undefined: in_addr is passed through unchecked, and alignment is the memory's responsibility.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2).
  - Word width constant (16).
  - Default TIMEOUT_CYCLES.
- One natural sub-module: mem_timeout_ctr, a saturating up-counter with clear, enable and a terminal-count output.
- The hold register uses the existing register module with writeEn = completion & load.

Test Plan:
1. Hit: load, addr 0x0010, mem_stall = 0, mem_done = 1 same cycle, data 0xBEEF → stall_n stays 1; out_mem_out = 0xBEEF that cycle; mem_rd pulses for 1 cycle.
2. Miss: store 0x1234 to 0x0020, mem_stall = 0, mem_done 3 cycles later → stall_n = 0 for exactly 3 cycles; mem_wr high 1 cycle; hold register unchanged.
3. Busy memory: load with mem_stall = 1 for 2 cycles, then accepted, done 1 cycle later → mem_rd high 3 consecutive cycles with constant mem_addr; stall_n low 3 cycles; data latched.
4. Timeout: TIMEOUT_CYCLES = 4, load accepted, mem_done never asserts → err = 1 after 4 WAIT cycles; stall_n returns to 1; FSM in IDLE; err persists.
5. Async reset asserted in WAIT mid-access → outputs reset immediately without a clock edge; stall_n = 1, busy = 0, err = 0.
6. With ALIGN_CHECK_EN: load addr 0x0011 → no mem_rd; err = 1; stall_n = 1. Without it → mem_rd issued to 0x0011.
